timer_ctrl: RTL and testbench

- Sequencing controller for the MM:SS BCD countdown/alarm datapath on the board.
- Owns the four setpoint digits and the digit-edit cursor, and runs the start/pause/abort/alarm state machine.
- Drives load and count-enable into the BCD counter datapath, and blink and alarm indications toward the SegDisplay and buzzer path.
- Inputs are already-debounced single-cycle pulses plus a 1 Hz tick from the clock divider.

---
 rtl/timer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_timer_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: sequencing controller for the MM:SS BCD countdown/alarm datapath.
// Owns the four setpoint digits and the edit cursor. Runs the
// idle/set/run/pause/alarm state machine. Every output is registered.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   tick               1 Hz single-cycle pulse from the clock divider
//   start_p            debounced start/pause pulse
//   sel_p              debounced mode/select pulse
//   inc_p              debounced increase pulse
//   cnt_done           datapath reached 00:00; only looked at in RUN
//   set_d0..set_d3     setpoint digits (ss units, ss tens, mm units, mm tens)
//   load               one-cycle load strobe into the counter datapath
//   cnt_en             datapath count enable
//   blink_mask         per-digit blank request toward the display
//   alarm              buzzer/alarm indication
//   state              current state encoding (debug/LEDs)
module timer_ctrl #(
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_p,
    input  logic       sel_p,
    input  logic       inc_p,
    input  logic       cnt_done,
    output logic [3:0] set_d0,
    output logic [3:0] set_d1,
    output logic [3:0] set_d2,
    output logic [3:0] set_d3,
    output logic       load,
    output logic       cnt_en,
    output logic [3:0] blink_mask,
    output logic       alarm,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSet   = 3'd1,
        StRun   = 3'd2,
        StPause = 3'd3,
        StAlarm = 3'd4
    } state_e;

    localparam logic [7:0] AlarmInit = 8'(ALARM_SECS);

    state_e          state_q, state_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic [1:0]      cursor_q, cursor_d;
    logic            blink_q, blink_d;
    logic [7:0]      alarm_cnt_q, alarm_cnt_d;
    logic            load_q, load_d;
    logic            cnt_en_q, cnt_en_d;
    logic [3:0]      blink_mask_q, blink_mask_d;
    logic            alarm_q, alarm_d;

    logic            setpoint_nz;
    logic [3:0]      digit_max;

    assign setpoint_nz = |digit_q;
    // Odd cursor positions are tens digits and wrap at 5.
    assign digit_max   = cursor_q[0] ? 4'd5 : 4'd9;

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        cursor_d    = cursor_q;
        alarm_cnt_d = alarm_cnt_q;
        load_d      = 1'b0;
        blink_d     = tick ? ~blink_q : blink_q;

        // Only the highest-priority event acts in a cycle.
        case (state_q)
            StIdle, StSet: begin
                if (start_p) begin
                    if (setpoint_nz) begin
                        state_d = StRun;
                        load_d  = 1'b1;
                    end
                end else if (sel_p) begin
                    if (state_q == StIdle) begin
                        state_d  = StSet;
                        cursor_d = 2'd0;
                    end else if (cursor_q == 2'd3) begin
                        state_d  = StIdle;
                        cursor_d = 2'd0;
                    end else begin
                        cursor_d = cursor_q + 2'd1;
                    end
                end else if (inc_p && (state_q == StSet)) begin
                    digit_d[cursor_q] = (digit_q[cursor_q] >= digit_max) ? 4'd0
                                                                       : digit_q[cursor_q] + 4'd1;
                end
            end
            StRun: begin
                // A stale cnt_done in the load cycle predates the new count.
                if (cnt_done && !load_q) begin
                    state_d     = StAlarm;
                    alarm_cnt_d = AlarmInit;
                end else if (start_p) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (start_p) begin
                    state_d = StRun;
                end else if (sel_p) begin
                    state_d = StIdle;
                end
            end
            StAlarm: begin
                if (start_p || sel_p || inc_p) begin
                    state_d     = StIdle;
                    alarm_cnt_d = 8'd0;
                end else if (tick) begin
                    if (alarm_cnt_q <= 8'd1) begin
                        state_d     = StIdle;
                        alarm_cnt_d = 8'd0;
                    end else begin
                        alarm_cnt_d = alarm_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are derived from next-state values so they line up with state.
        cnt_en_d     = (state_d == StRun) && !load_d;
        alarm_d      = (state_d == StAlarm);
        blink_mask_d = 4'b0000;
        if (state_d == StSet) begin
            blink_mask_d[cursor_d] = blink_d;
        end else if (state_d == StAlarm) begin
            blink_mask_d = {4{blink_d}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            digit_q      <= '0;
            cursor_q     <= 2'd0;
            blink_q      <= 1'b0;
            alarm_cnt_q  <= 8'd0;
            load_q       <= 1'b0;
            cnt_en_q     <= 1'b0;
            blink_mask_q <= 4'b0000;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cursor_q     <= cursor_d;
            blink_q      <= blink_d;
            alarm_cnt_q  <= alarm_cnt_d;
            load_q       <= load_d;
            cnt_en_q     <= cnt_en_d;
            blink_mask_q <= blink_mask_d;
            alarm_q      <= alarm_d;
        end
    end

    assign set_d0     = digit_q[0];
    assign set_d1     = digit_q[1];
    assign set_d2     = digit_q[2];
    assign set_d3     = digit_q[3];
    assign load       = load_q;
    assign cnt_en     = cnt_en_q;
    assign blink_mask = blink_mask_q;
    assign alarm      = alarm_q;
    assign state      = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: one task per scenario, inline comparisons.
module tb_timer_ctrl;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start_p;
    logic       sel_p;
    logic       inc_p;
    logic       cnt_done;
    logic [3:0] set_d0, set_d1, set_d2, set_d3;
    logic       load;
    logic       cnt_en;
    logic [3:0] blink_mask;
    logic       alarm;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;
    logic ph = 1'b0;  // expected blink phase, toggled by every tick driven

    timer_ctrl #(.ALARM_SECS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_p    (start_p),
        .sel_p      (sel_p),
        .inc_p      (inc_p),
        .cnt_done   (cnt_done),
        .set_d0     (set_d0),
        .set_d1     (set_d1),
        .set_d2     (set_d2),
        .set_d3     (set_d3),
        .load       (load),
        .cnt_en     (cnt_en),
        .blink_mask (blink_mask),
        .alarm      (alarm),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs starting 1 ns after an edge; returns 1 ns after the next edge.
    task automatic step(input logic st, input logic se, input logic in, input logic tk,
                        input logic dn);
        start_p  = st;
        sel_p    = se;
        inc_p    = in;
        tick     = tk;
        cnt_done = dn;
        @(posedge clk);
        #1;
        if (tk && !reset) ph = ~ph;
        if (reset) ph = 1'b0;
        start_p  = 1'b0;
        sel_p    = 1'b0;
        inc_p    = 1'b0;
        tick     = 1'b0;
        cnt_done = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic seen_load;
        apply_reset(2);
        n_cmp++;
        if (state !== 3'd0) begin
            n_err++; $display("FAIL reset_state: got %0d expected 0", state);
        end
        n_cmp++;
        if ({set_d3, set_d2, set_d1, set_d0} !== 16'h0000) begin
            n_err++; $display("FAIL reset_digits: got %h expected 0000",
                              {set_d3, set_d2, set_d1, set_d0});
        end
        n_cmp++;
        if ({load, cnt_en, blink_mask, alarm} !== 7'b0) begin
            n_err++; $display("FAIL reset_outputs: got %b expected 0000000",
                              {load, cnt_en, blink_mask, alarm});
        end
        // Start with 00:00 setpoint and inc in IDLE are both ignored.
        seen_load = 1'b0;
        step(1, 0, 0, 0, 0);
        seen_load |= load;
        step(0, 0, 1, 0, 0);
        seen_load |= load;
        step(0, 0, 0, 0, 0);
        seen_load |= load;
        n_cmp++;
        if (state !== 3'd0 || seen_load !== 1'b0) begin
            n_err++; $display("FAIL zero_start: got state %0d load_seen %b expected 0 0",
                              state, seen_load);
        end
        n_cmp++;
        if ({set_d3, set_d2, set_d1, set_d0} !== 16'h0000) begin
            n_err++; $display("FAIL idle_inc: got %h expected 0000",
                              {set_d3, set_d2, set_d1, set_d0});
        end
    endtask

    task automatic test_digit_edit;
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd1 || blink_mask !== 4'b0000) begin
            n_err++; $display("FAIL enter_set: got state %0d mask %b expected 1 0000",
                              state, blink_mask);
        end
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
        n_cmp++;
        if (set_d0 !== 4'd7) begin
            n_err++; $display("FAIL edit_d0: got %0d expected 7", set_d0);
        end
        step(0, 0, 0, 1, 0);  // phase -> 1
        n_cmp++;
        if (blink_mask !== 4'b0001) begin
            n_err++; $display("FAIL blink_c0: got %b expected 0001", blink_mask);
        end
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (blink_mask !== 4'b0010) begin
            n_err++; $display("FAIL blink_c1: got %b expected 0010", blink_mask);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        n_cmp++;
        if (set_d1 !== 4'd0 || set_d0 !== 4'd7) begin
            n_err++; $display("FAIL edit_d1_wrap: got d1 %0d d0 %0d expected 0 7",
                              set_d1, set_d0);
        end
        step(0, 0, 0, 1, 0);  // phase -> 0
        n_cmp++;
        if (blink_mask !== 4'b0000) begin
            n_err++; $display("FAIL blink_off: got %b expected 0000", blink_mask);
        end
        step(0, 0, 0, 1, 0);  // phase -> 1
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd1 || blink_mask !== 4'b1000) begin
            n_err++; $display("FAIL cursor3: got state %0d mask %b expected 1 1000",
                              state, blink_mask);
        end
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd0 || blink_mask !== 4'b0000) begin
            n_err++; $display("FAIL set_exit: got state %0d mask %b expected 0 0000",
                              state, blink_mask);
        end
        // Re-entering SET must start at cursor 0.
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd1 || blink_mask !== 4'b0001) begin
            n_err++; $display("FAIL cursor_clear: got state %0d mask %b expected 1 0001",
                              state, blink_mask);
        end
    endtask

    task automatic test_run_pause;
        int loads;
        apply_reset(1);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd2 || load !== 1'b1 || cnt_en !== 1'b0) begin
            n_err++; $display("FAIL load_cycle: got st %0d load %b en %b expected 2 1 0",
                              state, load, cnt_en);
        end
        step(0, 0, 0, 0, 0);
        n_cmp++;
        if (load !== 1'b0 || cnt_en !== 1'b1) begin
            n_err++; $display("FAIL first_en: got load %b en %b expected 0 1", load, cnt_en);
        end
        step(1, 0, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd3 || cnt_en !== 1'b0) begin
            n_err++; $display("FAIL pause: got st %0d en %b expected 3 0", state, cnt_en);
        end
        loads = 0;
        step(1, 0, 0, 0, 0);
        loads += int'(load);
        n_cmp++;
        if (state !== 3'd2 || cnt_en !== 1'b1) begin
            n_err++; $display("FAIL resume: got st %0d en %b expected 2 1", state, cnt_en);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1, 0);  // sel/inc ignored in RUN
            loads += int'(load);
        end
        n_cmp++;
        if (loads !== 0 || state !== 3'd2 || set_d0 !== 4'd5) begin
            n_err++; $display("FAIL no_reload: got loads %0d st %0d d0 %0d expected 0 2 5",
                              loads, state, set_d0);
        end
    endtask

    task automatic test_expiry;
        step(0, 0, 0, 0, 1);
        n_cmp++;
        if (state !== 3'd4 || alarm !== 1'b1 || cnt_en !== 1'b0 || blink_mask !== {4{ph}}) begin
            n_err++; $display("FAIL alarm_entry: got st %0d al %b en %b mask %b exp 4 1 0 %b",
                              state, alarm, cnt_en, blink_mask, {4{ph}});
        end
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1, 0);
            n_cmp++;
            if (blink_mask !== {4{ph}} || state !== 3'd4) begin
                n_err++; $display("FAIL alarm_blink%0d: got st %0d mask %b expected 4 %b",
                                  i, state, blink_mask, {4{ph}});
            end
            step(0, 0, 0, 0, 0);
        end
        step(0, 0, 0, 1, 0);
        n_cmp++;
        if (state !== 3'd0 || alarm !== 1'b0 || blink_mask !== 4'b0000) begin
            n_err++; $display("FAIL alarm_timeout: got st %0d al %b mask %b expected 0 0 0000",
                              state, alarm, blink_mask);
        end
    endtask

    task automatic test_silence_abort;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);  // done during load cycle must be ignored
        n_cmp++;
        if (state !== 3'd2 || cnt_en !== 1'b1) begin
            n_err++; $display("FAIL stale_done: got st %0d en %b expected 2 1", state, cnt_en);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        n_cmp++;
        if (state !== 3'd0 || alarm !== 1'b0) begin
            n_err++; $display("FAIL silence: got st %0d al %b expected 0 0", state, alarm);
        end
        apply_reset(1);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_cmp++;
        if (state !== 3'd0 || cnt_en !== 1'b0 ||
            {set_d3, set_d2, set_d1, set_d0} !== 16'h1234) begin
            n_err++; $display("FAIL abort: got st %0d en %b set %h expected 0 0 1234",
                              state, cnt_en, {set_d3, set_d2, set_d1, set_d0});
        end
    endtask

    task automatic test_simultaneous;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        n_cmp++;
        if (state !== 3'd4) begin
            n_err++; $display("FAIL done_vs_start: got %0d expected 4", state);
        end
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        if (!ph) step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0);
        n_cmp++;
        if (blink_mask !== 4'b0010 || {set_d3, set_d2, set_d1, set_d0} !== 16'h1234) begin
            n_err++; $display("FAIL sel_vs_inc: got mask %b set %h expected 0010 1234",
                              blink_mask, {set_d3, set_d2, set_d1, set_d0});
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        apply_reset(1);
        n_cmp++;
        if (state !== 3'd0 || cnt_en !== 1'b0 || load !== 1'b0 ||
            {set_d3, set_d2, set_d1, set_d0} !== 16'h0000) begin
            n_err++; $display("FAIL reset_in_run: got st %0d en %b ld %b set %h exp 0 0 0 0000",
                              state, cnt_en, load, {set_d3, set_d2, set_d1, set_d0});
        end
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        start_p  = 1'b0;
        sel_p    = 1'b0;
        inc_p    = 1'b0;
        cnt_done = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_digit_edit();
        test_run_pause();
        test_expiry();
        test_silence_abort();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
